// File: rtl/bidiag_band_extract_if.sv
// Handshake/bus bundle between the bidiagonalization core, the band extractor
// and the downstream SVD stage.
interface bidiag_band_extract_if #(
  parameter int BIT_NUM = 18
);
  logic                      valid_i;
  logic signed [BIT_NUM-1:0] R_i;
  logic signed [BIT_NUM-1:0] I_i;
  logic signed [BIT_NUM-1:0] R_o;
  logic signed [BIT_NUM-1:0] I_o;
  logic [2:0]                idx_o;
  logic                      last_o;
  logic                      valid_o;
  logic                      ready_i;
  logic                      residue_o;
  logic                      overrun_o;

  modport master (
    output valid_i, R_i, I_i, ready_i,
    input  R_o, I_o, idx_o, last_o, valid_o, residue_o, overrun_o
  );

  modport slave (
    input  valid_i, R_i, I_i, ready_i,
    output R_o, I_o, idx_o, last_o, valid_o, residue_o, overrun_o
  );
endinterface

// File: rtl/bidiag_band_extract.sv
// Collects a 4x4 row-major complex frame, keeps the 7 bidiagonal band entries,
// flags off-band residue above THRESH and drains the band over valid/ready.
module bidiag_band_extract #(
  parameter int                 BIT_NUM      = 18,
  parameter int                 CHANNEL_SIZE = 16,
  parameter logic [BIT_NUM-1:0] THRESH       = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  bidiag_band_extract_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(CHANNEL_SIZE);
  localparam int                 BAND_N   = 7;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(CHANNEL_SIZE - 1);
  localparam logic [2:0]         LAST_IDX = 3'(BAND_N - 1);
  localparam logic [BIT_NUM:0]   THR_EXT  = {1'b0, THRESH};

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      resid_q, resid_d;
  logic                      ovr_q, ovr_d;
  logic signed [BIT_NUM-1:0] band_r_q [BAND_N];
  logic signed [BIT_NUM-1:0] band_r_d [BAND_N];
  logic signed [BIT_NUM-1:0] band_i_q [BAND_N];
  logic signed [BIT_NUM-1:0] band_i_d [BAND_N];
  logic                      valid_q, valid_d;
  logic signed [BIT_NUM-1:0] r_o_q, r_o_d;
  logic signed [BIT_NUM-1:0] i_o_q, i_o_d;
  logic [2:0]                idx_q, idx_d;
  logic                      last_q, last_d;

  logic [3:0]                slot;
  logic [2:0]                nxt_idx;

  // {hit, band index}: diagonal when col==row, superdiagonal when col==row+1
  function automatic logic [3:0] band_slot(input logic [CNT_W-1:0] c);
    logic [1:0] row;
    logic [1:0] col;
    logic       hit;
    logic [2:0] idx;
    row = c[3:2];
    col = c[1:0];
    hit = ({1'b0, col} == {1'b0, row}) || ({1'b0, col} == ({1'b0, row} + 3'd1));
    idx = {row, 1'b0} + {2'b00, (col != row)};
    return {hit, idx};
  endfunction

  // One extra bit so that the most negative sample has a representable magnitude
  function automatic logic [BIT_NUM:0] mag(input logic signed [BIT_NUM-1:0] x);
    logic signed [BIT_NUM:0] ext;
    ext = {x[BIT_NUM-1], x};
    return ext[BIT_NUM] ? $unsigned(-ext) : $unsigned(ext);
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    resid_d  = resid_q;
    ovr_d    = ovr_q;
    band_r_d = band_r_q;
    band_i_d = band_i_q;
    valid_d  = valid_q;
    r_o_d    = r_o_q;
    i_o_d    = i_o_q;
    idx_d    = idx_q;
    last_d   = last_q;
    slot     = band_slot(cnt_q);
    nxt_idx  = idx_q + 3'd1;

    case (state_q)
      COLLECT: begin
        if (bus.valid_i) begin
          if (slot[3]) begin
            band_r_d[slot[2:0]] = bus.R_i;
            band_i_d[slot[2:0]] = bus.I_i;
          end else if ((mag(bus.R_i) > THR_EXT) || (mag(bus.I_i) > THR_EXT)) begin
            resid_d = 1'b1;
          end
          cnt_d = cnt_q + 1'b1;
          // Entry 0 was stored long ago, so the first beat can be presented at once
          if (cnt_q == LAST_CNT) begin
            state_d = DRAIN;
            valid_d = 1'b1;
            idx_d   = 3'd0;
            last_d  = 1'b0;
            r_o_d   = band_r_q[0];
            i_o_d   = band_i_q[0];
          end
        end
      end
      DRAIN: begin
        if (bus.valid_i) begin
          ovr_d = 1'b1;
        end
        if (bus.ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = COLLECT;
            valid_d = 1'b0;
            idx_d   = 3'd0;
            last_d  = 1'b0;
            r_o_d   = '0;
            i_o_d   = '0;
            cnt_d   = '0;
            resid_d = 1'b0;
          end else begin
            idx_d  = nxt_idx;
            r_o_d  = band_r_q[nxt_idx];
            i_o_d  = band_i_q[nxt_idx];
            last_d = (nxt_idx == LAST_IDX);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      resid_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < BAND_N; k++) begin
        band_r_q[k] <= '0;
        band_i_q[k] <= '0;
      end
      valid_q <= 1'b0;
      r_o_q   <= '0;
      i_o_q   <= '0;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resid_q  <= resid_d;
      ovr_q    <= ovr_d;
      band_r_q <= band_r_d;
      band_i_q <= band_i_d;
      valid_q  <= valid_d;
      r_o_q    <= r_o_d;
      i_o_q    <= i_o_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
    end
  end

  assign bus.R_o       = r_o_q;
  assign bus.I_o       = i_o_q;
  assign bus.idx_o     = idx_q;
  assign bus.last_o    = last_q;
  assign bus.valid_o   = valid_q;
  assign bus.residue_o = valid_q & resid_q;
  assign bus.overrun_o = ovr_q;

endmodule

// File: tb/tb_bidiag_band_extract.sv
// Self-checking bench: directed vector table plus randomized frames against a
// matrix-level reference model of the band extractor.
module tb_bidiag_band_extract;

  localparam int BIT_NUM = 18;
  localparam int THRESH  = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bidiag_band_extract_if #(.BIT_NUM(BIT_NUM)) bus ();

  bidiag_band_extract #(
    .BIT_NUM(BIT_NUM),
    .CHANNEL_SIZE(16),
    .THRESH(18'(THRESH))
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    string name;
    int    fill;
    int    gap_max;
    int    ready_mode;
    bit    inject;
    int    mod_pos;
    int    mod_r;
    int    mod_i;
    bit    exp_residue;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;
  int   fr_r[16];
  int   fr_i[16];
  bit   ovr_model = 1'b0;

  task automatic check_output(input string name, input logic signed [31:0] act,
                              input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int rand18();
    logic [17:0] u;
    u = 18'($urandom());
    return int'($signed(u));
  endfunction

  function automatic bit is_band(input int p);
    int row;
    int col;
    row = p / 4;
    col = p % 4;
    return (col == row) || (col == row + 1);
  endfunction

  // Matrix position of band entry k: d_r at (r,r), e_r at (r,r+1)
  function automatic int band_pos(input int k);
    return (k / 2) * 5 + (k % 2);
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit model_residue();
    bit r;
    r = 1'b0;
    for (int p = 0; p < 16; p++)
      if (!is_band(p) && (iabs(fr_r[p]) > THRESH || iabs(fr_i[p]) > THRESH))
        r = 1'b1;
    return r;
  endfunction

  task automatic build_frame(input vec_t v);
    for (int p = 0; p < 16; p++) begin
      if (v.fill == 0) begin
        fr_r[p] = is_band(p) ? p : 0;
        fr_i[p] = is_band(p) ? -p : 0;
      end else if (is_band(p)) begin
        fr_r[p] = rand18();
        fr_i[p] = rand18();
      end else begin
        fr_r[p] = int'($urandom_range(0, 160)) - 80;
        fr_i[p] = int'($urandom_range(0, 160)) - 80;
      end
    end
    if (v.mod_pos >= 0) begin
      fr_r[v.mod_pos] = v.mod_r;
      fr_i[v.mod_pos] = v.mod_i;
    end
  endtask

  // Drives nbeats entries at negedges; returns whether valid_o was seen early
  task automatic apply_stimulus(input int nbeats, input int gap_max, output bit saw_valid);
    saw_valid = 1'b0;
    for (int p = 0; p < nbeats; p++) begin
      repeat ($urandom_range(0, gap_max)) begin
        saw_valid |= bus.valid_o;
        bus.valid_i = 1'b0;
        @(negedge clk);
      end
      saw_valid |= bus.valid_o;
      bus.valid_i = 1'b1;
      bus.R_i     = 18'(fr_r[p]);
      bus.I_i     = 18'(fr_i[p]);
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic drain_frame(input vec_t v, input bit exp_res);
    int   got = 0;
    int   cyc = 0;
    int   stall_left = 5;
    bit   stall_done = 1'b0;
    bit   tog = 1'b0;
    bit   rdy;
    bit   prev_stall = 1'b0;
    logic signed [31:0] prev_r = 0;
    logic signed [31:0] prev_i = 0;
    logic signed [31:0] prev_idx = 0;
    while (got < 7 && cyc < 200) begin
      bus.valid_i = v.inject && (cyc < 2);
      bus.R_i     = 18'(rand18());
      bus.I_i     = 18'(rand18());
      if (prev_stall) begin
        check_output("stall_valid", bus.valid_o, 1);
        check_output("stall_idx", bus.idx_o, prev_idx);
        check_output("stall_r", bus.R_o, prev_r);
        check_output("stall_i", bus.I_o, prev_i);
      end
      case (v.ready_mode)
        0: rdy = 1'b1;
        1: begin
          if (bus.valid_o && bus.idx_o == 3'd2 && !stall_done) begin
            rdy = 1'b0;
            stall_left--;
            if (stall_left == 0) stall_done = 1'b1;
          end else if (stall_done) begin
            rdy = tog;
            tog = !tog;
          end else begin
            rdy = 1'b1;
          end
        end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.ready_i = rdy;
      if (bus.valid_o && rdy) begin
        check_output({v.name, "_idx"}, bus.idx_o, got);
        check_output({v.name, "_r"}, bus.R_o, fr_r[band_pos(got)]);
        check_output({v.name, "_i"}, bus.I_o, fr_i[band_pos(got)]);
        check_output({v.name, "_last"}, bus.last_o, (got == 6));
        if (got == 6) check_output({v.name, "_residue"}, bus.residue_o, exp_res);
        got++;
      end
      prev_stall = bus.valid_o && !rdy;
      prev_r     = bus.R_o;
      prev_i     = bus.I_o;
      prev_idx   = bus.idx_o;
      @(negedge clk);
      cyc++;
    end
    bus.valid_i = 1'b0;
    if (v.inject) ovr_model = 1'b1;
    check_output({v.name, "_beats"}, got, 7);
    check_output({v.name, "_valid_fall"}, bus.valid_o, 0);
    check_output({v.name, "_residue_idle"}, bus.residue_o, 0);
    check_output({v.name, "_overrun"}, bus.overrun_o, ovr_model);
  endtask

  task automatic run_frame(input vec_t v, input bit exp_res);
    bit saw;
    build_frame(v);
    apply_stimulus(16, v.gap_max, saw);
    check_output({v.name, "_quiet"}, saw, 0);
    check_output({v.name, "_latency"}, bus.valid_o, 1);
    drain_frame(v, exp_res);
  endtask

  task automatic check_reset_outputs(input string name);
    check_output({name, "_valid"}, bus.valid_o, 0);
    check_output({name, "_r"}, bus.R_o, 0);
    check_output({name, "_i"}, bus.I_o, 0);
    check_output({name, "_idx"}, bus.idx_o, 0);
    check_output({name, "_last"}, bus.last_o, 0);
    check_output({name, "_residue"}, bus.residue_o, 0);
    check_output({name, "_overrun"}, bus.overrun_o, 0);
  endtask

  initial begin
    vec_t v;
    bit   saw;
    vecs[0] = '{"basic",     0, 0, 0, 1'b0, -1,       0,   0, 1'b0};
    vecs[1] = '{"im_m65",    0, 0, 0, 1'b0,  8,       0, -65, 1'b1};
    vecs[2] = '{"im_m64",    0, 0, 0, 1'b0,  8,       0, -64, 1'b0};
    vecs[3] = '{"r_min",     0, 0, 0, 1'b0,  3, -131072,   0, 1'b1};
    vecs[4] = '{"r_p64",     0, 0, 0, 1'b0,  2,      64,   0, 1'b0};
    vecs[5] = '{"r_p65",     0, 0, 0, 1'b0, 14,      65,   0, 1'b1};
    vecs[6] = '{"stall",     0, 0, 1, 1'b0, -1,       0,   0, 1'b0};
    vecs[7] = '{"gaps",      0, 3, 0, 1'b0, -1,       0,   0, 1'b0};
    vecs[8] = '{"overrun",   0, 0, 0, 1'b1, -1,       0,   0, 1'b0};
    vecs[9] = '{"after_ovr", 0, 0, 0, 1'b0, -1,       0,   0, 1'b0};

    rst_n       = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.R_i     = '0;
    bus.I_i     = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 10; n++) run_frame(vecs[n], vecs[n].exp_residue);

    for (int n = 0; n < 6; n++) begin
      v = '{$sformatf("rand%0d", n), 1, int'($urandom_range(0, 2)), 2,
            1'($urandom_range(0, 1)), -1, 0, 0, 1'b0};
      build_frame(v);
      apply_stimulus(16, v.gap_max, saw);
      check_output({v.name, "_quiet"}, saw, 0);
      check_output({v.name, "_latency"}, bus.valid_o, 1);
      drain_frame(v, model_residue());
    end

    // Reset in the middle of a drain
    build_frame(vecs[0]);
    apply_stimulus(16, 0, saw);
    bus.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    ovr_model = 1'b0;
    check_reset_outputs("rst_drain");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset after 9 beats of a frame carrying residue, then a clean frame
    v = vecs[0];
    v.mod_pos = 2;
    v.mod_r   = 1000;
    build_frame(v);
    apply_stimulus(9, 0, saw);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = vecs[0];
    v.name = "post_rst";
    run_frame(v, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
